word_stream_mux: RTL
====================

Name: word_stream_mux

Overview:
- Parametrised N-to-1 word selector for the AES datapath, successor to the fixed 4:1 32-bit combinational word mux.
- Adds valid/ready handshaking on every input and on the output, a registered output stage, and two selection modes: explicit select or round-robin.
- Sits between the state/key word sources (round-key words, SubBytes/MixColumns columns) and downstream consumers that may stall.

Parameters:
- WIDTH, 32, data word width in bits.
- N_IN, 4, number of input channels (2..16).
- SEL_W, $clog2(N_IN), select/source-index width (derived; do not override).

Ports:
- Clk  input  1  system clock; all logic on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- in_data  input  N_IN*WIDTH  packed input words; channel i at bits [i*WIDTH +: WIDTH].
- in_valid  input  N_IN  per-channel valid.
- in_last  input  N_IN  per-channel end-of-packet flag; used only when the optional feature is compiled in.
- in_ready  output  N_IN  per-channel ready (one-hot or zero).
- mode  input  1  0 = MODE_SEL (explicit), 1 = MODE_RR (round-robin).
- sel  input  SEL_W  channel index, used in MODE_SEL.
- out_data  output  WIDTH  registered output word.
- out_src  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (synchronous, Reset=1 at a Clk edge): out_valid=0, out_data=0, out_src=0, RR pointer=0, lock state idle. While Reset=1, in_ready=0.
- Output stage: a single register. can_load = !out_valid || out_ready.
- Transfer: an input transfer occurs on channel g when in_valid[g] && in_ready[g]. On that edge, out_data<=in_data[g], out_src<=g, out_valid<=1.
- Drain: if out_ready && out_valid with no new load, out_valid<=0 and out_data holds its value.
- Latency: 1 cycle from input handshake to out_valid. Full throughput of 1 word/cycle when out_ready is held high.
- Grant (combinational, computed each cycle; in_ready[g] = grant[g] && can_load):
  - MODE_SEL: grant = one-hot(sel) if in_valid[sel], else 0.
  - sel >= N_IN (non-power-of-2 N_IN): grant = 0, nothing is accepted.
  - MODE_RR: the first valid channel at or after the pointer, searching upward and wrapping N_IN-1 -> 0.
- RR pointer: updates only on a transfer, to (g+1) mod N_IN; it holds otherwise. The pointer is kept but not consulted in MODE_SEL.
- No valid inputs: grant = 0, out_valid drains normally.
- Stall: out_valid=1 && out_ready=0 gives in_ready=0 and holds out_data/out_src stable. Sources must hold their data.
- Simultaneous accept and drain: a new load takes priority and out_valid stays 1.
- mode/sel may change on any cycle. The change takes effect on the grant in the same cycle; a word already registered is unaffected.
- Reset mid-stall: the pending output word is discarded.

Optional Feature:
- Macro: WORD_STREAM_MUX_PKT_LOCK_EN.
- With macro defined:
  - After a transfer from channel g with in_last[g]=0, the grant is locked to g, ignoring mode, sel and the RR pointer, until a transfer from g with in_last[g]=1.
  - Lock state: IDLE -> LOCKED(g) on a non-last beat; LOCKED -> IDLE on the last beat.
  - The RR pointer advances only on the last beat.
  - Reset returns the lock state to IDLE.
- Without macro: in_last is ignored and arbitration is per word, as described above.

Decomposition:
- Package aes_mux_pkg holds:
  - typedef enum logic {MODE_SEL=1'b0, MODE_RR=1'b1} mux_mode_e;
  - lock-state enum {LK_IDLE, LK_LOCKED}.
- Sub-module rr_arbiter (params N; ports Clk, Reset, req[N], advance, grant[N], grant_idx). It owns the pointer and the wrap search.
- word_stream_mux instantiates rr_arbiter and muxes its output with the MODE_SEL grant.

Test Plan:
- Reset: Reset=1 for 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0; first accept occurs on the cycle after Reset falls.
- MODE_SEL: sel=2, in_data ch2=32'hDEADBEEF, all valid, out_ready=1 -> in_ready=4'b0100, and next cycle out_data=32'hDEADBEEF, out_src=2.
- MODE_RR: all 4 channels valid continuously, out_ready=1 -> out_src sequence 0,1,2,3,0,... at one word per cycle. With only ch1 and ch3 valid -> sequence 1,3,1,3.
- Backpressure: out_ready=0 for 5 cycles with output full -> in_ready=0 and out_data stable. When out_ready returns to 1 -> a new word is loaded that same edge and no data is lost or duplicated (scoreboard).
- Illegal select: N_IN=3, sel=3 -> in_ready=0 and out_valid stays 0.
- PKT_LOCK (macro on), MODE_RR: ch0 sends a 3-beat packet (last on beat 3) while ch1 is valid -> out_src=0,0,0 then 1.

Source files
------------

// File: rtl/aes_mux_pkg.sv
// Shared types for the AES word stream multiplexer: selection mode and packet-lock state.
package aes_mux_pkg;

    typedef enum logic {MODE_SEL = 1'b0, MODE_RR = 1'b1} mux_mode_e;

    typedef enum logic {LK_IDLE = 1'b0, LK_LOCKED = 1'b1} lock_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer, wrapping N-1 -> 0.
// The pointer moves to adv_idx+1 when advance is asserted by the owner of the transfer.
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [N-1:0]  req,
    input  logic          advance,
    input  logic [IW-1:0] adv_idx,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          found_s;

    function automatic logic [IW-1:0] cand_idx(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) begin
            s = s - N;
        end else begin
            s = s;
        end
        return IW'(s);
    endfunction

    // Wrapping priority search starting at the pointer
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found_s && req[cand_idx(ptr_q, k)]) begin
                found_s                   = 1'b1;
                grant[cand_idx(ptr_q, k)] = 1'b1;
                grant_idx                 = cand_idx(ptr_q, k);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next pointer: one past the channel that just transferred
    always_comb begin
        if (advance) begin
            ptr_d = (adv_idx == IW'(N - 1)) ? '0 : adv_idx + IW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/word_stream_mux.sv
// N-to-1 handshaked word selector with a single registered output stage.
// Optional packet locking on in_last is enabled by defining WORD_STREAM_MUX_PKT_LOCK_EN.
module word_stream_mux
    import aes_mux_pkg::*;
#(
    parameter int  WIDTH = 32,
    parameter int  N_IN  = 4,
    localparam int SEL_W = $clog2(N_IN)
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic [N_IN-1:0]         in_valid,
    input  logic [N_IN-1:0]         in_last,
    output logic [N_IN-1:0]         in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_src,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] words_s [N_IN];
    logic [N_IN-1:0]  sel_grant_s;
    logic [N_IN-1:0]  rr_grant_s;
    logic [N_IN-1:0]  grant_s;
    logic [SEL_W-1:0] rr_idx_s;
    logic [SEL_W-1:0] grant_idx_s;
    logic             can_load_s;
    logic             xfer_s;
    logic             advance_s;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_src_q,  out_src_d;
    logic             out_valid_q, out_valid_d;

    for (genvar i = 0; i < N_IN; i++) begin : g_unpack
        assign words_s[i] = in_data[i*WIDTH +: WIDTH];
    end

    assign can_load_s = !out_valid_q || out_ready;

    // Explicit select; indices beyond the last channel grant nothing
    always_comb begin
        if (int'(sel) < N_IN) begin
            sel_grant_s = in_valid[sel] ? (N_IN'(1) << sel) : '0;
        end else begin
            sel_grant_s = '0;
        end
    end

    rr_arbiter #(.N(N_IN)) u_rr (
        .Clk       (Clk),
        .Reset     (Reset),
        .req       (in_valid),
        .advance   (advance_s),
        .adv_idx   (grant_idx_s),
        .grant     (rr_grant_s),
        .grant_idx (rr_idx_s)
    );

`ifdef WORD_STREAM_MUX_PKT_LOCK_EN
    lock_state_e      lk_state_q;
    logic [SEL_W-1:0] lk_idx_q;

    // Packet lock FSM: hold the grant on one channel from first beat to last beat
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lk_state_q <= LK_IDLE;
            lk_idx_q   <= '0;
        end else begin
            case (lk_state_q)
                LK_IDLE: begin
                    if (xfer_s && !in_last[grant_idx_s]) begin
                        lk_state_q <= LK_LOCKED;
                        lk_idx_q   <= grant_idx_s;
                    end
                end
                LK_LOCKED: begin
                    if (xfer_s && in_last[grant_idx_s]) begin
                        lk_state_q <= LK_IDLE;
                    end
                end
                default: lk_state_q <= LK_IDLE;
            endcase
        end
    end

    assign advance_s = xfer_s && in_last[grant_idx_s];
`else
    logic unused_last_s;
    assign unused_last_s = ^in_last;
    assign advance_s     = xfer_s;
`endif

    // Grant source: lock overrides mode, otherwise explicit select or round-robin
    always_comb begin
        grant_s     = '0;
        grant_idx_s = '0;
`ifdef WORD_STREAM_MUX_PKT_LOCK_EN
        if (lk_state_q == LK_LOCKED) begin
            grant_idx_s = lk_idx_q;
            grant_s     = in_valid[lk_idx_q] ? (N_IN'(1) << lk_idx_q) : '0;
        end else
`endif
        begin
            case (mux_mode_e'(mode))
                MODE_SEL: begin
                    grant_s     = sel_grant_s;
                    grant_idx_s = sel;
                end
                MODE_RR: begin
                    grant_s     = rr_grant_s;
                    grant_idx_s = rr_idx_s;
                end
                default: begin
                    grant_s     = '0;
                    grant_idx_s = '0;
                end
            endcase
        end
    end

    assign in_ready = (Reset || !can_load_s) ? '0 : grant_s;
    assign xfer_s   = |in_ready;

    // Output stage next state: a new load wins over a drain
    always_comb begin
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        out_valid_d = out_valid_q;
        if (xfer_s) begin
            out_data_d  = words_s[grant_idx_s];
            out_src_d   = grant_idx_s;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign out_valid = out_valid_q;

endmodule
